// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised SPI master. A synchronised rising edge on SIMCK launches one
// full-duplex DATA_W-bit frame to one of NUM_SS slaves in any CPOL/CPHA mode,
// framed by programmable SSEL guard times (PRE_CYCLES / POST_CYCLES).
//
// Ports
//   clk      : system clock, all logic on posedge
//   reset_n  : asynchronous active-low reset
//   en       : block enable; low aborts the frame and idles the block
//   SIMCK    : asynchronous frame trigger (rising edge)
//   data_in  : tx word, latched on trigger
//   clkdiv   : SCK half-period minus 1 in clk cycles, latched on trigger
//   mode     : {CPOL,CPHA}, latched on trigger
//   ss_idx   : slave index, latched on trigger (out of range = no select)
//   MISO     : serial data from slave (asynchronous)
//   MOSI     : serial data to slave
//   SSEL     : active-low slave selects
//   SCK      : serial clock
//   rx_data  : last completed rx word
//   busy     : high while a frame is in flight, through the done cycle
//   done     : one-cycle pulse at frame end
//   overrun  : sticky, trigger seen while busy; cleared by reset_n or en low
//
// Configuration macro: SPI_LSB_FIRST_EN selects LSB-first shifting
// (tx sends data[0] first, rx_data[0] holds the first received bit).
// -----------------------------------------------------------------------------
module spi_master_param #(
  parameter int DATA_W      = 32,
  parameter int CLKDIV_W    = 24,
  parameter int NUM_SS      = 1,
  parameter int PRE_CYCLES  = 16,
  parameter int POST_CYCLES = 16,
  localparam int SSW        = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                SIMCK,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [CLKDIV_W-1:0] clkdiv,
  input  logic [1:0]          mode,
  input  logic [SSW-1:0]      ss_idx,
  input  logic                MISO,
  output logic                MOSI,
  output logic [NUM_SS-1:0]   SSEL,
  output logic                SCK,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int BIT_W  = $clog2(DATA_W) + 1;
  localparam int PP_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int PP_W   = $clog2(PP_MAX) + 1;
  // One down-counter serves the guard times and the SCK half-period.
  localparam int CNT_W  = (PP_W > CLKDIV_W + 1) ? PP_W : CLKDIV_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_simck_sync;
  logic [1:0]          r_miso_sync;
  logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data;
  logic [CNT_W-1:0]    r_cnt;
  logic [CLKDIV_W-1:0] r_half_m1;
  logic [BIT_W-1:0]    r_bits;
  logic                r_cpol, r_cpha, r_sck, r_overrun;
  logic [NUM_SS-1:0]   r_ssel, w_ssel_dec;
  logic                w_trig, w_miso, w_cnt_zero, w_sck_edge, w_leading;
  logic                w_sample, w_shift, w_last_edge, w_mosi;
  logic [DATA_W-1:0]   w_tx_shifted, w_rx_shifted;

  // Edge = oldest 0 followed by two 1s, so the trigger is seen once per rise.
  assign w_trig     = ~r_simck_sync[2] & r_simck_sync[1] & r_simck_sync[0];
  assign w_miso     = r_miso_sync[1];
  assign w_cnt_zero = (r_cnt == '0);
  // The PRE timeout itself produces the first leading SCK edge.
  assign w_sck_edge = ((r_state == S_PRE) || (r_state == S_SHIFT)) && w_cnt_zero;
  assign w_leading  = (r_sck == r_cpol);
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  assign w_sample   = w_sck_edge && (w_leading ^ r_cpha);
  // CPHA=1 skips the first leading edge (bit 0 is already presented);
  // CPHA=0 skips the trailing edge after the final sample.
  assign w_shift    = w_sck_edge && !(w_leading ^ r_cpha) &&
                      (r_cpha ? (r_bits != '0) : (r_bits != BIT_W'(DATA_W)));
  // The frame ends on the trailing edge of the last bit.
  assign w_last_edge = w_sck_edge && !w_leading &&
                       (r_cpha ? (r_bits == BIT_W'(DATA_W - 1)) : (r_bits == BIT_W'(DATA_W)));

`ifdef SPI_LSB_FIRST_EN
  assign w_mosi       = r_tx[0];
  assign w_tx_shifted = {1'b0, r_tx[DATA_W-1:1]};
  assign w_rx_shifted = {w_miso, r_rx[DATA_W-1:1]};
`else
  assign w_mosi       = r_tx[DATA_W-1];
  assign w_tx_shifted = {r_tx[DATA_W-2:0], 1'b0};
  assign w_rx_shifted = {r_rx[DATA_W-2:0], w_miso};
`endif

  assign MOSI    = w_mosi;
  assign SSEL    = r_ssel;
  assign SCK     = r_sck;
  assign rx_data = r_rx_data;
  assign overrun = r_overrun;

  // Decode of the live ss_idx; values >= NUM_SS leave every line high.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    w_ssel_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      w_ssel_dec[i] = (ss_idx != SSW'(i));
    end
  end

  // NOTE: asynchronous active-low reset; every flop returns to a known value immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_simck_sync <= '0;
      r_miso_sync  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_simck_sync <= {r_simck_sync[1:0], SIMCK};
      r_miso_sync  <= {r_miso_sync[0], MISO};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_trig)      w_state_nxt = S_PRE;
        S_PRE:   if (w_cnt_zero)  w_state_nxt = S_SHIFT;
        S_SHIFT: if (w_last_edge) w_state_nxt = S_POST;
        S_POST:  if (w_cnt_zero)  w_state_nxt = S_DONE;
        S_DONE:                   w_state_nxt = S_IDLE;
        default:                  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Datapath: latching, guard/half-period counter, SCK, shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cnt     <= '0;
      r_half_m1 <= '0;
      r_bits    <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sck     <= 1'b0;
      r_overrun <= 1'b0;
      r_ssel    <= '1;
    end else if (!en) begin
      // Abort: release the slave, park SCK, drop the sticky flag; rx_data is kept.
      r_ssel    <= '1;
      r_sck     <= mode[1];
      r_overrun <= 1'b0;
    end else begin
      // A trigger outside IDLE (including the DONE cycle) is dropped and flagged.
      if (w_trig && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_sck <= mode[1];
          if (w_trig) begin
            r_tx      <= data_in;
            r_rx      <= '0;
            r_bits    <= '0;
            r_cpol    <= mode[1];
            r_cpha    <= mode[0];
            // H = max(clkdiv,2)+1, stored as H-1 for the reload.
            r_half_m1 <= (clkdiv < CLKDIV_W'(2)) ? CLKDIV_W'(2) : clkdiv;
            r_cnt     <= CNT_W'(PRE_CYCLES - 1);
            r_ssel    <= w_ssel_dec;
          end
        end
        S_PRE, S_SHIFT: begin
          if (w_cnt_zero) begin
            r_sck <= ~r_sck;
            r_cnt <= w_last_edge ? CNT_W'(POST_CYCLES - 1) : CNT_W'(r_half_m1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
          if (w_sample) begin
            r_rx   <= w_rx_shifted;
            r_bits <= r_bits + BIT_W'(1);
          end
          if (w_shift) r_tx <= w_tx_shifted;
        end
        S_POST: begin
          if (w_cnt_zero) begin
            // Publish the word together with the done pulse.
            r_ssel    <= '1;
            r_rx_data <= r_rx;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
